// File: rtl/huff_bit_packer.sv
// Bit packer: concatenates LSB-first variable-length codeword bundles into a continuous
// stream and emits fixed-width words; flush drains the partial tail word marked out_last.
module huff_bit_packer #(
   parameter int IN_WIDTH          = 16,
   parameter int IN_LEN_WIDTH      = 5,
   parameter int OUTPUT_BLOCK_SIZE = 8,
   parameter int NB_WIDTH          = $clog2(OUTPUT_BLOCK_SIZE + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_WIDTH-1:0]          in_bits,
   input  logic [IN_LEN_WIDTH-1:0]      in_len,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUTPUT_BLOCK_SIZE-1:0] out_word,
   output logic [NB_WIDTH-1:0]          out_nbits,
   output logic                         out_last,
   output logic                         flush_done
);

   localparam int AW = IN_WIDTH + OUTPUT_BLOCK_SIZE - 1;
   localparam int CW = $clog2(AW + 1);
   localparam logic [CW-1:0]           OBS_C = CW'(OUTPUT_BLOCK_SIZE);
   localparam logic [IN_LEN_WIDTH-1:0] IW_C  = IN_LEN_WIDTH'(IN_WIDTH);

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   state_t                  state, state_nxt;
   logic [AW-1:0]           acc;
   logic [CW-1:0]           count;
   logic [IN_LEN_WIDTH-1:0] len_eff;
   logic [IN_WIDTH-1:0]     masked;
   logic                    below_obs;
   logic                    out_free;
   logic                    do_push;
   logic                    do_pop;
   logic                    do_last;
   logic                    do_fdone;

   // Bits above the clamped length are zeroed so acc stays zero above count.
   always_comb begin
      len_eff = (in_len > IW_C) ? IW_C : in_len;
      masked  = '0;
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
         if (i < 32'(len_eff)) masked[i] = in_bits[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (flush) state_nxt = FLUSH;
         FLUSH:   if (below_obs && out_free) state_nxt = DONE;
         DONE:    if (!out_valid) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      below_obs = (count < OBS_C);
      out_free  = !out_valid || out_ready;
      in_ready  = rst_n && (state == RUN) && below_obs;
      do_push   = in_valid && in_ready;
      do_pop    = !below_obs && out_free;
      do_last   = (state == FLUSH) && below_obs && (count != '0) && out_free;
      do_fdone  = (state == DONE) && !out_valid;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc        <= '0;
         count      <= '0;
         out_word   <= '0;
         out_nbits  <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= do_fdone;
         if (do_push) begin
            acc   <= acc | (AW'(masked) << count);
            count <= count + CW'(len_eff);
         end else if (do_pop) begin
            acc   <= acc >> OUTPUT_BLOCK_SIZE;
            count <= count - OBS_C;
         end else if (do_last) begin
            acc   <= '0;
            count <= '0;
         end
         // Pop and last-word load share the output register; they never coincide.
         if (do_pop || do_last) begin
            out_word  <= acc[OUTPUT_BLOCK_SIZE-1:0];
            out_nbits <= do_pop ? NB_WIDTH'(OUTPUT_BLOCK_SIZE) : NB_WIDTH'(count);
            out_last  <= do_last;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_huff_bit_packer.sv
// Testbench for huff_bit_packer: directed table, hand-written corner sequences and
// randomized traffic checked against a bit-queue reference model.
module tb_huff_bit_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_bits = '0;
   logic [4:0]  in_len = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_word;
   logic [3:0]  out_nbits;
   logic        out_last;
   logic        flush_done;

   huff_bit_packer #(
      .IN_WIDTH(16),
      .IN_LEN_WIDTH(5),
      .OUTPUT_BLOCK_SIZE(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_bits(in_bits),
      .in_len(in_len),
      .flush(flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_word(out_word),
      .out_nbits(out_nbits),
      .out_last(out_last),
      .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] w;
      logic [3:0] nb;
      logic       lst;
   } word_t;

   typedef struct {
      logic [15:0] b0;
      logic [4:0]  l0;
      logic [15:0] b1;
      logic [4:0]  l1;
      int          nw;
      logic [7:0]  w;
      logic [3:0]  nb;
      logic        lst;
   } vec_t;

   int    nvec = 0;
   int    nerr = 0;
   int    fd_count = 0;
   bit    fd_seen, fd_pending, in_acc, rand_rdy;
   bit    bitq[$];
   word_t expq[$];
   word_t obs[$];
   vec_t  tbl[9];

   function automatic void chk(string name, int unsigned act, int unsigned exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Reference: the stream is a bit queue; every 8 queued bits form one full word.
   function automatic void model_push(logic [15:0] b, logic [4:0] l);
      int n;
      word_t x;
      n = (l > 5'd16) ? 16 : int'(l);
      for (int i = 0; i < n; i++) bitq.push_back(b[i]);
      while (bitq.size() >= 8) begin
         x = '0;
         for (int i = 0; i < 8; i++) x.w[i] = bitq.pop_front();
         x.nb = 4'd8;
         expq.push_back(x);
      end
   endfunction

   function automatic void model_flush();
      word_t x;
      if (bitq.size() > 0) begin
         x = '0;
         for (int i = 0; i < bitq.size(); i++) x.w[i] = bitq[i];
         x.nb  = 4'(bitq.size());
         x.lst = 1'b1;
         expq.push_back(x);
         bitq.delete();
      end
      fd_pending = 1'b1;
   endfunction

   function automatic void sample();
      word_t e;
      in_acc  = 1'b0;
      fd_seen = 1'b0;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            obs.push_back({out_word, out_nbits, out_last});
            if (expq.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL extra_word: got 0x%0h, expected no word", out_word);
            end else begin
               e = expq.pop_front();
               chk("out_word", out_word, e.w);
               chk("out_nbits", out_nbits, e.nb);
               chk("out_last", out_last, e.lst);
            end
         end
         if (in_valid && in_ready) begin
            model_push(in_bits, in_len);
            in_acc = 1'b1;
         end
         if (flush) model_flush();
         if (flush_done) begin
            fd_seen = 1'b1;
            fd_count++;
            chk("flush_done_expected", fd_pending, 1);
            chk("flush_done_drained", expq.size(), 0);
            fd_pending = 1'b0;
         end
      end
   endfunction

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic push(input logic [15:0] b, input logic [4:0] l);
      bit got;
      got = 1'b0;
      in_valid = 1'b1;
      in_bits  = b;
      in_len   = l;
      for (int k = 0; k < 300 && !got; k++) begin
         step();
         got = in_acc;
      end
      in_valid = 1'b0;
      if (!got) chk("push_timeout", 0, 1);
   endtask

   task automatic do_flush();
      bit got;
      flush = 1'b1;
      step();
      flush = 1'b0;
      got = fd_seen;
      for (int k = 0; k < 300 && !got; k++) begin
         step();
         got = fd_seen;
      end
      if (!got) chk("flush_done_timeout", 0, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int fd_before;
      tbl[0] = '{16'h0005, 5'd3,  16'h001F, 5'd5,  1, 8'hFD, 4'd8, 1'b0};
      tbl[1] = '{16'hFFFF, 5'd4,  16'h0000, 5'd4,  1, 8'h0F, 4'd8, 1'b0};
      tbl[2] = '{16'h0005, 5'd3,  16'h0000, 5'd0,  1, 8'h05, 4'd3, 1'b1};
      tbl[3] = '{16'hABCD, 5'd16, 16'h0000, 5'd0,  2, 8'hCD, 4'd8, 1'b0};
      tbl[4] = '{16'h1234, 5'd31, 16'h0000, 5'd0,  2, 8'h34, 4'd8, 1'b0};
      tbl[5] = '{16'h00FF, 5'd8,  16'h0000, 5'd0,  1, 8'hFF, 4'd8, 1'b0};
      tbl[6] = '{16'h0003, 5'd2,  16'hFFFF, 5'd1,  1, 8'h07, 4'd3, 1'b1};
      tbl[7] = '{16'hFFFF, 5'd0,  16'h0000, 5'd0,  0, 8'h00, 4'd0, 1'b0};
      tbl[8] = '{16'h001F, 5'd5,  16'h03FF, 5'd10, 2, 8'hFF, 4'd8, 1'b0};

      rand_rdy = 1'b0;
      repeat (3) step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_word", out_word, 0);
      chk("rst_out_nbits", out_nbits, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_flush_done", flush_done, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      // Latency: accepted in cycle t, word visible in t+2.
      push(16'h00FF, 5'd8);
      chk("lat_t1_out_valid", out_valid, 0);
      chk("lat_t1_in_ready", in_ready, 0);
      step();
      chk("lat_t2_out_valid", out_valid, 1);
      chk("lat_t2_out_word", out_word, 8'hFF);
      do_flush();

      push(16'hABCD, 5'd16);
      chk("multi_in_ready_full", in_ready, 0);
      step();
      chk("multi_w0", out_word, 8'hCD);
      chk("multi_in_ready_half", in_ready, 0);
      step();
      chk("multi_w1", out_word, 8'hAB);
      chk("multi_w1_valid", out_valid, 1);
      chk("multi_in_ready_empty", in_ready, 1);
      do_flush();

      out_ready = 1'b0;
      obs.delete();
      push(16'h1234, 5'd16);
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_out_valid", out_valid, 1);
         chk("bp_out_word", out_word, 8'h34);
         chk("bp_in_ready", in_ready, 0);
         step();
      end
      out_ready = 1'b1;
      do_flush();
      chk("bp_nwords", obs.size(), 2);
      if (obs.size() == 2) begin
         chk("bp_first", obs[0].w, 8'h34);
         chk("bp_second", obs[1].w, 8'h12);
      end

      for (int v = 0; v < 9; v++) begin
         obs.delete();
         fd_before = fd_count;
         push(tbl[v].b0, tbl[v].l0);
         push(tbl[v].b1, tbl[v].l1);
         do_flush();
         repeat (3) step();
         chk($sformatf("vec%0d_nwords", v), obs.size(), tbl[v].nw);
         chk($sformatf("vec%0d_fd_pulses", v), fd_count - fd_before, 1);
         if (obs.size() > 0) begin
            chk($sformatf("vec%0d_word", v), obs[0].w, tbl[v].w);
            chk($sformatf("vec%0d_nbits", v), obs[0].nb, tbl[v].nb);
            chk($sformatf("vec%0d_last", v), obs[0].lst, tbl[v].lst);
         end
      end

      // Mid-stream reset must discard the three buffered ones.
      push(16'h0007, 5'd3);
      rst_n = 1'b0;
      bitq.delete();
      expq.delete();
      fd_pending = 1'b0;
      step();
      step();
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      step();
      obs.delete();
      push(16'h0000, 5'd8);
      do_flush();
      chk("midrst_nwords", obs.size(), 1);
      if (obs.size() > 0) chk("midrst_word", obs[0].w, 8'h00);

      rand_rdy = 1'b1;
      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 2)) step();
         push(16'($urandom()), 5'($urandom_range(0, 20)));
         if ($urandom_range(0, 15) == 0) do_flush();
      end
      do_flush();
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      chk("final_expq_empty", expq.size(), 0);
      chk("final_bitq_empty", bitq.size(), 0);
      chk("final_out_valid", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
